nco_multiwave: RTL and testbench

//   Parametrised successor NCO: phase accumulator + quarter-wave sine LUT, generalised in phase/output/LUT width.

---
 rtl/nco_multiwave.sv | 197 +++++++++++++++++++
 tb/tb_nco_multiwave.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/nco_multiwave.sv
// Multi-waveform NCO: phase accumulator with shadowed controls and a 2-stage pipeline
// that yields in-phase and 90-degree samples of sine, square, triangle or sawtooth.
module nco_multiwave #(
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned LUT_AW  = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      sync,
    input  logic                      load,
    input  logic [PHASE_W-1:0]        freq_in,
    input  logic [PHASE_W-1:0]        offset_in,
    input  logic [1:0]                mode_in,
    output logic signed [OUT_W-1:0]   wave_out,
    output logic signed [OUT_W-1:0]   quad_out,
    output logic                      out_valid,
    output logic                      wrap_out
);

    localparam int unsigned LUT_N  = 1 << LUT_AW;
    // Only the phase MSBs that any waveform reads are carried into stage 2.
    localparam int unsigned KEEP_W = (LUT_AW + 2 > OUT_W + 1) ? (LUT_AW + 2) : (OUT_W + 1);

    localparam logic [OUT_W-1:0]  AMP_V     = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]  NEG_AMP_V = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};
    localparam logic [OUT_W-1:0]  MIN_V     = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [KEEP_W-1:0] QTR_K     = {2'b01, {(KEEP_W-2){1'b0}}};
    localparam longint            PI_Q30    = 64'sd3373259426;

    if (OUT_W < 4 || LUT_AW + 2 > PHASE_W || OUT_W + 1 > PHASE_W) begin : g_bad_params
        $error("nco_multiwave: illegal PHASE_W/OUT_W/LUT_AW combination");
    end

    // round(A*sin(pi*k/2^(LUT_AW+1))) via Q30 Taylor series, evaluated at elaboration.
    function automatic longint lut_entry(input int unsigned k);
        longint x;
        longint term;
        longint acc;
        longint amp;
        x    = (PI_Q30 * longint'(k)) >>> (LUT_AW + 1);
        acc  = x;
        term = x;
        for (int n = 1; n <= 8; n++) begin
            term = (term * x) >>> 30;
            term = (term * x) >>> 30;
            term = -term / longint'((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        amp = (longint'(1) << (OUT_W - 1)) - 1;
        return (amp * acc + (longint'(1) << 29)) >>> 30;
    endfunction

    logic [OUT_W-1:0] lut [LUT_N];
    for (genvar k = 0; k < LUT_N; k++) begin : g_lut
        assign lut[k] = OUT_W'(lut_entry(k));
    end

    // Accumulator, shadow registers and pipeline state
    logic [PHASE_W-1:0] phase_q,  phase_d;
    logic               acc_wrap_q, acc_wrap_d;
    logic [PHASE_W-1:0] freq_q,   freq_d;
    logic [PHASE_W-1:0] offset_q, offset_d;
    logic [1:0]         mode_q,   mode_d;
    logic [KEEP_W-1:0]  p1_q,     p1_d;
    logic [1:0]         mode1_q,  mode1_d;
    logic               valid1_q, valid1_d;
    logic               wrap1_q,  wrap1_d;
    logic [OUT_W-1:0]   wave_q,   wave_d;
    logic [OUT_W-1:0]   quad_q,   quad_d;
    logic               valid2_q, valid2_d;
    logic               wrap2_q,  wrap2_d;
    logic [PHASE_W:0]   sum_w;

    logic [KEEP_W-1:0]  ch_phase [2];
    logic [OUT_W-1:0]   ch_val   [2];

    assign ch_phase[0] = p1_q;
    assign ch_phase[1] = p1_q + QTR_K;

    // Waveform shaping, one instance per output channel
    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [1:0]        quad;
        logic [LUT_AW-1:0] idx;
        logic [LUT_AW-1:0] addr;
        logic [OUT_W-1:0]  mag;
        logic [OUT_W-1:0]  sin_v;
        logic [OUT_W-1:0]  tri_f;
        logic [OUT_W-1:0]  tri_v;
        logic [OUT_W-1:0]  saw_s;
        logic [OUT_W-1:0]  saw_v;
        logic [OUT_W-1:0]  sq_v;
        logic [OUT_W-1:0]  val;

        always_comb begin
            quad  = ch_phase[c][KEEP_W-1 -: 2];
            idx   = ch_phase[c][KEEP_W-3 -: LUT_AW];
            // Odd quadrants mirror the table: 2^LUT_AW - idx, with idx==0 meaning the peak.
            addr  = quad[0] ? (LUT_AW'(0) - idx) : idx;
            mag   = (quad[0] && (idx == '0)) ? AMP_V : lut[addr];
            sin_v = quad[1] ? (OUT_W'(0) - mag) : mag;

            tri_f = {1'b0, ch_phase[c][KEEP_W-3 -: OUT_W-1]};
            case (quad)
                2'd0:    tri_v = tri_f;
                2'd1:    tri_v = AMP_V - tri_f;
                2'd2:    tri_v = OUT_W'(0) - tri_f;
                default: tri_v = tri_f - AMP_V;
            endcase

            saw_s = {~ch_phase[c][KEEP_W-1], ch_phase[c][KEEP_W-2 -: OUT_W-1]};
            saw_v = (saw_s == MIN_V) ? NEG_AMP_V : saw_s;
            sq_v  = ch_phase[c][KEEP_W-1] ? NEG_AMP_V : AMP_V;

            case (mode1_q)
                2'd0:    val = sin_v;
                2'd1:    val = sq_v;
                2'd2:    val = tri_v;
                default: val = saw_v;
            endcase
        end

        assign ch_val[c] = val;
    end

    always_comb begin
        phase_d    = phase_q;
        acc_wrap_d = 1'b0;
        freq_d     = freq_q;
        offset_d   = offset_q;
        mode_d     = mode_q;
        sum_w      = {1'b0, phase_q} + {1'b0, freq_q};

        if (sync) begin
            phase_d = '0;
        end else if (en) begin
            phase_d    = sum_w[PHASE_W-1:0];
            acc_wrap_d = sum_w[PHASE_W];
        end

        if (load) begin
            freq_d   = freq_in;
            offset_d = offset_in;
            mode_d   = mode_in;
        end

        // Stage 1 captures offset and mode together so a sample never mixes settings.
        p1_d     = KEEP_W'((phase_q + offset_q) >> (PHASE_W - KEEP_W));
        mode1_d  = mode_q;
        valid1_d = en;
        wrap1_d  = acc_wrap_q;

        wave_d   = ch_val[0];
        quad_d   = ch_val[1];
        valid2_d = valid1_q;
        wrap2_d  = wrap1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q    <= '0;
            acc_wrap_q <= 1'b0;
            freq_q     <= '0;
            offset_q   <= '0;
            mode_q     <= '0;
            p1_q       <= '0;
            mode1_q    <= '0;
            valid1_q   <= 1'b0;
            wrap1_q    <= 1'b0;
            wave_q     <= '0;
            quad_q     <= '0;
            valid2_q   <= 1'b0;
            wrap2_q    <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            acc_wrap_q <= acc_wrap_d;
            freq_q     <= freq_d;
            offset_q   <= offset_d;
            mode_q     <= mode_d;
            p1_q       <= p1_d;
            mode1_q    <= mode1_d;
            valid1_q   <= valid1_d;
            wrap1_q    <= wrap1_d;
            wave_q     <= wave_d;
            quad_q     <= quad_d;
            valid2_q   <= valid2_d;
            wrap2_q    <= wrap2_d;
        end
    end

    assign wave_out  = wave_q;
    assign quad_out  = quad_q;
    assign out_valid = valid2_q;
    assign wrap_out  = wrap2_q;

endmodule

// File: tb/tb_nco_multiwave.sv
// Self-checking bench for nco_multiwave: table of single-sample vectors plus
// hand-written sequences for latency, mid-run load/sync and async reset.
module tb_nco_multiwave;

    localparam int unsigned PHASE_W = 32;
    localparam int unsigned OUT_W   = 8;
    localparam int unsigned LUT_AW  = 6;
    localparam logic [31:0] F26 = 32'h0400_0000;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    en;
    logic                    sync;
    logic                    load;
    logic [PHASE_W-1:0]      freq_in;
    logic [PHASE_W-1:0]      offset_in;
    logic [1:0]              mode_in;
    logic signed [OUT_W-1:0] wave_out;
    logic signed [OUT_W-1:0] quad_out;
    logic                    out_valid;
    logic                    wrap_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nco_multiwave #(.PHASE_W(PHASE_W), .OUT_W(OUT_W), .LUT_AW(LUT_AW)) dut (
        .clk(clk), .rst(rst), .en(en), .sync(sync), .load(load),
        .freq_in(freq_in), .offset_in(offset_in), .mode_in(mode_in),
        .wave_out(wave_out), .quad_out(quad_out),
        .out_valid(out_valid), .wrap_out(wrap_out)
    );

    typedef struct {
        string       name;
        logic [1:0]  mode;
        logic [31:0] offset;
        int          n;
        int          wave;
        int          quad;
        bit          wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input int w, input int q, input int v, input int wr);
        check({name, ".wave"},  int'(wave_out),  w);
        check({name, ".quad"},  int'(quad_out),  q);
        check({name, ".valid"}, int'(out_valid), v);
        check({name, ".wrap"},  int'(wrap_out),  wr);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; sync = 1'b0; load = 1'b0;
        freq_in = '0; offset_in = '0; mode_in = 2'd0;
        step();
        rst = 1'b0;
    endtask

    // Loads settings with en low, then raises en: returns in cycle t0 with P=0.
    task automatic start_run(input logic [31:0] f, input logic [31:0] off, input logic [1:0] m);
        load = 1'b1; freq_in = f; offset_in = off; mode_in = m; en = 1'b0;
        step();
        load = 1'b0; en = 1'b1;
    endtask

    initial begin
        vecs.push_back('{"sin_n0",   2'd0, 32'd0,        0,    0,  127, 1'b0});
        vecs.push_back('{"sin_n8",   2'd0, 32'd0,        8,   90,   90, 1'b0});
        vecs.push_back('{"sin_n16",  2'd0, 32'd0,       16,  127,    0, 1'b0});
        vecs.push_back('{"sin_n32",  2'd0, 32'd0,       32,    0, -127, 1'b0});
        vecs.push_back('{"sin_n48",  2'd0, 32'd0,       48, -127,    0, 1'b0});
        vecs.push_back('{"sin_n64",  2'd0, 32'd0,       64,    0,  127, 1'b1});
        vecs.push_back('{"sin_n65",  2'd0, 32'd0,       65,   12,  126, 1'b0});
        vecs.push_back('{"sin_n128", 2'd0, 32'd0,      128,    0,  127, 1'b1});
        vecs.push_back('{"sq_n0",    2'd1, 32'd0,        0,  127,  127, 1'b0});
        vecs.push_back('{"sq_n31",   2'd1, 32'd0,       31,  127, -127, 1'b0});
        vecs.push_back('{"sq_n32",   2'd1, 32'd0,       32, -127, -127, 1'b0});
        vecs.push_back('{"sq_n63",   2'd1, 32'd0,       63, -127,  127, 1'b0});
        vecs.push_back('{"tri_n8",   2'd2, 32'd0,        8,   64,   63, 1'b0});
        vecs.push_back('{"tri_n16",  2'd2, 32'd0,       16,  127,    0, 1'b0});
        vecs.push_back('{"tri_n40",  2'd2, 32'd0,       40,  -64,  -63, 1'b0});
        vecs.push_back('{"saw_n0",   2'd3, 32'd0,        0, -127,  -64, 1'b0});
        vecs.push_back('{"saw_n32",  2'd3, 32'd0,       32,    0,   64, 1'b0});
        vecs.push_back('{"saw_n63",  2'd3, 32'd0,       63,  124,  -68, 1'b0});
        vecs.push_back('{"off_n0",   2'd0, 32'h4000_0000, 0, 127,    0, 1'b0});
        vecs.push_back('{"off_n16",  2'd0, 32'h4000_0000, 16,  0, -127, 1'b0});
        vecs.push_back('{"off_n64",  2'd0, 32'h4000_0000, 64, 127,   0, 1'b1});

        // Reset state
        rst = 1'b1; en = 1'b0; sync = 1'b0; load = 1'b0;
        freq_in = '0; offset_in = '0; mode_in = 2'd0;
        #2;
        check_out("reset", 0, 0, 0, 0);
        step();
        rst = 1'b0;

        // Single-sample vectors, each from a fresh reset
        foreach (vecs[i]) begin
            do_reset();
            start_run(F26, vecs[i].offset, vecs[i].mode);
            repeat (vecs[i].n + 2) step();
            check_out(vecs[i].name, vecs[i].wave, vecs[i].quad, 1, int'(vecs[i].wrap));
        end

        // Two-cycle latency and en gating with held phase
        do_reset();
        start_run(F26, 32'd0, 2'd0);
        step();
        check("lat.t1.valid", int'(out_valid), 0);
        step();
        check_out("lat.t2", 0, 127, 1, 0);
        en = 1'b0;
        step();
        en = 1'b1;
        step();
        check_out("hold.t4", 25, 125, 0, 0);
        step();
        check_out("hold.t5", 25, 125, 1, 0);

        // Mid-run mode/offset change: old sample intact, next fully new
        do_reset();
        start_run(F26, 32'd0, 2'd0);
        repeat (16) step();
        load = 1'b1; mode_in = 2'd1; offset_in = 32'h4000_0000;
        step();
        load = 1'b0;
        step();
        check_out("modechg.old", 127, 0, 1, 0);
        step();
        check_out("modechg.new", -127, -127, 1, 0);

        // Mid-run load freq=2^27 together with sync
        do_reset();
        start_run(F26, 32'd0, 2'd0);
        repeat (10) step();
        load = 1'b1; sync = 1'b1; freq_in = 32'h0800_0000;
        step();
        load = 1'b0; sync = 1'b0;
        repeat (2) step();
        check_out("sync.first", 0, 127, 1, 0);
        repeat (8) step();
        check_out("sync.p8", 127, 0, 1, 0);
        repeat (23) step();
        check("sync.p31.wrap", int'(wrap_out), 0);
        step();
        check_out("sync.p32", 0, 127, 1, 1);

        // Asynchronous reset between edges, then shadow registers back to defaults
        do_reset();
        start_run(F26, 32'd0, 2'd0);
        repeat (18) step();
        check_out("prerst", 127, 0, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        check_out("asyncrst", 0, 0, 0, 0);
        step();
        rst = 1'b0;
        repeat (2) step();
        check_out("postrst.f0", 0, 127, 1, 0);
        step();
        check_out("postrst.f0b", 0, 127, 1, 0);
        load = 1'b1; freq_in = 32'h8000_0000; mode_in = 2'd0; offset_in = '0;
        step();
        load = 1'b0;
        repeat (2) step();
        check_out("half.s0", 0, 127, 1, 0);
        step();
        check_out("half.s1", 0, -127, 1, 0);
        step();
        check_out("half.s2", 0, 127, 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
